rcla_block_subtractor_19: RTL and testbench
===========================================

RCLA_BLOCK_SUBTRACTOR_19 -- requirements
Module: rcla_block_subtractor_19

Interface
REQ-001 SHALL have parameter: none (operand width fixed at 19; block partition fixed at 4,4,4,4,3 bits, LSB first).
REQ-002 SHALL have port: clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operands present.
REQ-005 SHALL have port: in_ready  output  1  block accepts operands.
REQ-006 SHALL have port: x  input  19  minuend, unsigned.
REQ-007 SHALL have port: y  input  19  subtrahend, unsigned.
REQ-008 SHALL have port: out_valid  output  1  result present.
REQ-009 SHALL have port: out_ready  input  1  consumer takes result.
REQ-010 SHALL have port: d  output  19  difference x-y modulo 2^19.
REQ-011 SHALL have port: borrow  output  1  1 when x<y (unsigned).

Function
REQ-012 SHALL compute d = x + ~y + 1, one block per cycle, each block using 4-bit-style carry look-ahead (generate/propagate per bit, block carries from G/P terms), block carry-in = previous block carry-out, block 0 carry-in = 1.
REQ-013 SHALL implement states IDLE, RUN, DONE; reset state IDLE.
REQ-014 SHALL drive in_ready=1 only in IDLE with rst_n high.
REQ-015 SHALL, on in_valid&in_ready at edge T: capture x, ~y into internal registers, clear block index to 0, set carry to 1, enter RUN.
REQ-016 SHALL, in RUN, process block k on each edge (k=0..4), writing its sum bits into d register and its carry-out into carry register.
REQ-017 SHALL, on the edge processing block 4, set borrow = ~carry-out of block 4, enter DONE; out_valid=1 from edge T+5.
REQ-018 SHALL hold d, borrow, out_valid stable in DONE while out_ready=0.
REQ-019 SHALL, in DONE with out_ready=1, complete transfer at that edge, clear out_valid, enter IDLE; in_ready=1 the following cycle.
REQ-020 SHALL ignore x, y, in_valid outside IDLE; operand changes during RUN SHALL not affect the result.
REQ-021 SHALL hold d and borrow at last result in IDLE (not cleared after transfer).
REQ-022 SHALL keep d bits of unprocessed blocks undefined-to-observer; out_valid=0 during RUN.

Reset
REQ-023 SHALL, on rst_n low at any time (including mid-RUN or DONE), immediately force state IDLE, out_valid=0, d=0, borrow=0, in_ready=0, internal block index 0, carry 0.
REQ-024 SHALL resume with in_ready=1 on the first cycle after rst_n deasserts; an aborted operation SHALL produce no result.

Configuration
REQ-025 SHALL, when macro RCLA_SUB_SIGNED_OVF_EN is defined, add output ovf (1 bit) = two's-complement overflow of x-y treating x, y as signed 19-bit (carry into bit 18 XOR carry out of bit 18), registered with d, reset 0, valid with out_valid.
REQ-026 SHALL, when RCLA_SUB_SIGNED_OVF_EN is undefined, omit ovf port entirely; all other behaviour identical.

Verification
REQ-027 SHALL test: x=5, y=3 -> out_valid at T+5, d=2, borrow=0.
REQ-028 SHALL test: x=0, y=1 -> d=0x7FFFF, borrow=1; x=0x7FFFF, y=0x7FFFF -> d=0, borrow=0.
REQ-029 SHALL test cross-block borrow: x=0x10000, y=1 -> d=0x0FFFF, borrow=0; changing x during RUN leaves result unchanged.
REQ-030 SHALL test backpressure: out_ready=0 for 3 cycles in DONE -> d, borrow, out_valid held; in_ready=0 throughout; out_ready=1 -> IDLE next edge.
REQ-031 SHALL test reset mid-RUN (after block 2): out_valid stays 0, d=0; new operation x=9, y=4 afterwards -> d=5.
REQ-032 SHALL test with RCLA_SUB_SIGNED_OVF_EN: x=0x3FFFF, y=0x40000 -> d=0x7FFFF, ovf=1, borrow=1; x=5, y=3 -> ovf=0.

Source files
------------

// File: rtl/rcla_block_subtractor_19.sv
// Purpose: 19-bit unsigned subtractor x - y, one carry-lookahead block (4,4,4,4,3 bits) per cycle.
// Latency: 5 cycles from accept to out_valid; no new operand is accepted until the result is taken.
// Backpressure: result held in DONE until out_ready; optional signed overflow output under RCLA_SUB_SIGNED_OVF_EN.
module rcla_block_subtractor_19 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [18:0] x,
    input  logic [18:0] y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [18:0] d,
    output logic        borrow
`ifdef RCLA_SUB_SIGNED_OVF_EN
    ,
    output logic        ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [18:0] xr;
    logic [18:0] yn;
    logic [2:0]  blk;
    logic        carry;

    logic [3:0]  blk_a;
    logic [3:0]  blk_b;
    logic [3:0]  g;
    logic [3:0]  p;
    logic [4:0]  c;
    logic [3:0]  s;
    logic        blk_cout;

    // The 3-bit top block is zero-padded, so its carry-out is taken from c[3].
    always_comb begin
        blk_a = 4'd0;
        blk_b = 4'd0;
        case (blk)
            3'd0:    begin blk_a = xr[3:0];          blk_b = yn[3:0];          end
            3'd1:    begin blk_a = xr[7:4];          blk_b = yn[7:4];          end
            3'd2:    begin blk_a = xr[11:8];         blk_b = yn[11:8];         end
            3'd3:    begin blk_a = xr[15:12];        blk_b = yn[15:12];        end
            3'd4:    begin blk_a = {1'b0, xr[18:16]}; blk_b = {1'b0, yn[18:16]}; end
            default: begin blk_a = 4'd0;             blk_b = 4'd0;             end
        endcase
    end

    assign g = blk_a & blk_b;
    assign p = blk_a ^ blk_b;

    assign c[0] = carry;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign s        = p ^ c[3:0];
    assign blk_cout = (blk == 3'd4) ? c[3] : c[4];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)      state_d = RUN;
            RUN:     if (blk == 3'd4)   state_d = DONE;
            DONE:    if (out_ready)     state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr     <= 19'd0;
            yn     <= 19'd0;
            blk    <= 3'd0;
            carry  <= 1'b0;
            d      <= 19'd0;
            borrow <= 1'b0;
`ifdef RCLA_SUB_SIGNED_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        xr    <= x;
                        yn    <= ~y;
                        blk   <= 3'd0;
                        carry <= 1'b1;
                    end
                end
                RUN: begin
                    case (blk)
                        3'd0:    d[3:0]   <= s;
                        3'd1:    d[7:4]   <= s;
                        3'd2:    d[11:8]  <= s;
                        3'd3:    d[15:12] <= s;
                        3'd4:    d[18:16] <= s[2:0];
                        default: ;
                    endcase
                    carry <= blk_cout;
                    blk   <= blk + 3'd1;
                    if (blk == 3'd4) begin
                        borrow <= ~c[3];
`ifdef RCLA_SUB_SIGNED_OVF_EN
                        // carry into bit 18 vs carry out of bit 18
                        ovf    <= c[2] ^ c[3];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rcla_block_subtractor_19.sv
// Bench for rcla_block_subtractor_19: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results. Define RCLA_SUB_SIGNED_OVF_EN to cover ovf.
module tb_rcla_block_subtractor_19;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [18:0] x;
    logic [18:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [18:0] d;
    logic        borrow;
`ifdef RCLA_SUB_SIGNED_OVF_EN
    logic        ovf;
`endif

    int checks   = 0;
    int failures = 0;

    rcla_block_subtractor_19 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .borrow    (borrow)
`ifdef RCLA_SUB_SIGNED_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 busy, 2 result pending.
    int          m_state;
    int          m_cnt;
    logic [18:0] m_d;
    logic        m_b;
    logic        m_o;
    logic [18:0] p_d;
    logic        p_b;
    logic        p_o;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0;
            m_cnt   <= 0;
            m_d     <= '0;
            m_b     <= 1'b0;
            m_o     <= 1'b0;
        end else begin
            case (m_state)
                0: if (in_valid) begin
                    p_d     <= 19'((int'(x) - int'(y)) & 32'h7FFFF);
                    p_b     <= (x < y);
                    p_o     <= (x[18] != y[18]) && ((19'(x - y)) >> 18 != {18'd0, x[18]});
                    m_cnt   <= 5;
                    m_state <= 1;
                end
                1: begin
                    m_cnt <= m_cnt - 1;
                    if (m_cnt == 1) begin
                        m_state <= 2;
                        m_d     <= p_d;
                        m_b     <= p_b;
                        m_o     <= p_o;
                    end
                end
                default: if (out_ready) m_state <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_d", 32'(d), 32'd0);
            chk("rst_borrow", 32'(borrow), 32'd0);
        end else begin
            chk("cyc_in_ready", 32'(in_ready), 32'(m_state == 0));
            chk("cyc_out_valid", 32'(out_valid), 32'(m_state == 2));
            if (m_state != 1) begin
                chk("cyc_d", 32'(d), 32'(m_d));
                chk("cyc_borrow", 32'(borrow), 32'(m_b));
`ifdef RCLA_SUB_SIGNED_OVF_EN
                chk("cyc_ovf", 32'(ovf), 32'(m_o));
`endif
            end
        end
    end

    task automatic op(input logic [18:0] ax, input logic [18:0] ay, input logic [18:0] ed,
                      input logic eb, input logic eo, input int hold, input bit mid);
        int n;
        chk("pre_in_ready", 32'(in_ready), 32'd1);
        x = ax; y = ay; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (mid) begin
            x = ~ax; y = ~ay; in_valid = 1'b1;
        end
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("latency", 32'(n), 32'd5);
        chk("res_d", 32'(d), 32'(ed));
        chk("res_borrow", 32'(borrow), 32'(eb));
        chk("model_d", 32'(m_d), 32'(ed));
`ifdef RCLA_SUB_SIGNED_OVF_EN
        chk("res_ovf", 32'(ovf), 32'(eo));
`else
        if (eo) n = n;
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_d", 32'(d), 32'(ed));
            chk("hold_borrow", 32'(borrow), 32'(eb));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_d", 32'(d), 32'(ed));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("init_in_ready", 32'(in_ready), 32'd0);
        chk("init_d", 32'(d), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        op(19'd5,       19'd3,       19'd2,       1'b0, 1'b0, 0, 0);
        op(19'd0,       19'd1,       19'h7FFFF,   1'b1, 1'b0, 0, 0);
        op(19'h7FFFF,   19'h7FFFF,   19'd0,       1'b0, 1'b0, 0, 0);
        op(19'h10000,   19'd1,       19'h0FFFF,   1'b0, 1'b0, 0, 1);
        op(19'd1234,    19'd77,      19'd1157,    1'b0, 1'b0, 3, 0);
        op(19'h3FFFF,   19'h40000,   19'h7FFFF,   1'b1, 1'b1, 0, 0);
        op(19'h40000,   19'd1,       19'h3FFFF,   1'b0, 1'b1, 0, 0);

        // Abort an operation after three blocks have been processed.
        x = 19'h7FFFF; y = 19'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_d", 32'(d), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("abort_resume", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("abort_no_result", 32'(out_valid), 32'd0);
        end

        op(19'd9, 19'd4, 19'd5, 1'b0, 1'b0, 0, 0);
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
